// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : i2c_pkg
//  Description : Shared types and constants for the I2C MMIO bridge:
//                bridge FSM state encoding, register word offsets,
//                CTRL/STATUS bit positions and default timeout values.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2,
      ST_FINISH = 2'd3
   } bridge_state_e;

   // Register word offsets
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_TXDATA = 2'd1;
   localparam logic [1:0] REG_RXDATA = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // CTRL bit positions
   localparam int CTRL_DEV_LSB   = 0;
   localparam int CTRL_WRITE_BIT = 8;
   localparam int CTRL_MASK_LSB  = 12;
   localparam int CTRL_IE_BIT    = 16;
   localparam int CTRL_GO_BIT    = 31;

   // STATUS bit positions
   localparam int STAT_BUSY_BIT    = 0;
   localparam int STAT_DONE_BIT    = 1;
   localparam int STAT_TIMEOUT_BIT = 2;
   localparam int STAT_BADREQ_BIT  = 3;

   // Default timeouts (clk cycles)
   localparam int unsigned START_WAIT_DEF  = 16;
   localparam int unsigned RUN_TIMEOUT_DEF = 65536;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_mmio_bridge_if.sv
`default_nettype none
// ============================================================================
//  Interface   : i2c_mmio_bridge_if
//  Description : CPU memory-bus handshake between the core and the bridge.
//                req/we/addr/wdata/wstrb from the core, rdata/ready back.
//                master modport = core side, slave modport = bridge side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_mmio_bridge_if;
   logic        req;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;

   modport master (output req, we, addr, wdata, wstrb, input rdata, ready);
   modport slave  (input req, we, addr, wdata, wstrb, output rdata, ready);
endinterface
`default_nettype wire

// File: rtl/i2c_bridge_regs.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bridge_regs
//  Description : Register file and bus acknowledge for the I2C MMIO bridge.
//                Holds CTRL/TXDATA/RXDATA/STATUS, decodes GO and flags a
//                valid launch to the FSM.
//  Ports       : clk, reset        - clock, async active-high reset
//                bus               - CPU bus (slave modport)
//                busy_i            - FSM not idle
//                set_done_i        - FSM finishing a transaction
//                set_timeout_i     - FSM aborting on timeout
//                capture_rx_i      - load RXDATA from m_data_out_i
//                m_data_out_i      - master read data
//                go_o              - valid GO accepted this cycle
//                dev_addr_o/mask_o/write_o/txdata_o - master setup fields
//                irq_o             - level interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bridge_regs
   import i2c_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   i2c_mmio_bridge_if.slave        bus,
   input  logic                    busy_i,
   input  logic                    set_done_i,
   input  logic                    set_timeout_i,
   input  logic                    capture_rx_i,
   input  logic [31:0]             m_data_out_i,
   output logic                    go_o,
   output logic [6:0]              dev_addr_o,
   output logic [3:0]              mask_o,
   output logic                    write_o,
   output logic [31:0]             txdata_o,
   output logic                    irq_o
);

   logic [6:0]  dev_q,     dev_d;
   logic [3:0]  mask_q,    mask_d;
   logic        write_q,   write_d;
   logic        ie_q,      ie_d;
   logic [31:0] tx_q,      tx_d;
   logic [31:0] rx_q,      rx_d;
   logic        done_q,    done_d;
   logic        timeout_q, timeout_d;
   logic        badreq_q,  badreq_d;
   logic        ready_q,   ready_d;
   logic [31:0] rdata_q,   rdata_d;

   logic        w_access;
   logic        w_wr;
   logic        w_wr_ctrl;
   logic        w_wr_tx;
   logic        w_wr_stat;
   logic        w_go_req;
   logic        w_bad_go;
   logic [3:0]  w_mask_new;
   logic [31:0] w_rd_mux;

   // A request is taken only while no ack is pending, so each req is
   // accepted exactly once even though the core holds it into the ack cycle.
   assign w_access  = bus.req & ~ready_q;
   assign w_wr      = w_access & bus.we;
   // CTRL/TXDATA are frozen while a transaction runs; the write is still acked.
   assign w_wr_ctrl = w_wr & (bus.addr == REG_CTRL)   & ~busy_i;
   assign w_wr_tx   = w_wr & (bus.addr == REG_TXDATA) & ~busy_i;
   assign w_wr_stat = w_wr & (bus.addr == REG_STATUS) & bus.wstrb[0];

   // GO is judged against the mask as it will be after this same write.
   assign w_mask_new = (w_wr_ctrl & bus.wstrb[1]) ? bus.wdata[CTRL_MASK_LSB +: 4] : mask_q;
   assign w_go_req   = w_wr_ctrl & bus.wstrb[3] & bus.wdata[CTRL_GO_BIT];
   assign go_o       = w_go_req & (w_mask_new != 4'd0);
   assign w_bad_go   = w_go_req & (w_mask_new == 4'd0);

   always_comb begin
      w_rd_mux = 32'd0;
      case (bus.addr)
         REG_CTRL: begin
            w_rd_mux[CTRL_DEV_LSB +: 7]  = dev_q;
            w_rd_mux[CTRL_WRITE_BIT]     = write_q;
            w_rd_mux[CTRL_MASK_LSB +: 4] = mask_q;
            w_rd_mux[CTRL_IE_BIT]        = ie_q;
         end
         REG_TXDATA: w_rd_mux = tx_q;
         REG_RXDATA: w_rd_mux = rx_q;
         default: begin
            w_rd_mux[STAT_BUSY_BIT]    = busy_i;
            w_rd_mux[STAT_DONE_BIT]    = done_q;
            w_rd_mux[STAT_TIMEOUT_BIT] = timeout_q;
            w_rd_mux[STAT_BADREQ_BIT]  = badreq_q;
         end
      endcase
   end

   always_comb begin
      dev_d     = dev_q;
      mask_d    = w_mask_new;
      write_d   = write_q;
      ie_d      = ie_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      badreq_d  = badreq_q;
      ready_d   = w_access;
      rdata_d   = w_access ? w_rd_mux : rdata_q;

      if (w_wr_ctrl) begin
         if (bus.wstrb[0]) dev_d   = bus.wdata[CTRL_DEV_LSB +: 7];
         if (bus.wstrb[1]) write_d = bus.wdata[CTRL_WRITE_BIT];
         if (bus.wstrb[2]) ie_d    = bus.wdata[CTRL_IE_BIT];
      end

      if (w_wr_tx) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wstrb[b]) tx_d[8*b +: 8] = bus.wdata[8*b +: 8];
         end
      end

      if (capture_rx_i) rx_d = m_data_out_i;

      // Order matters: software clear first, hardware set last so set wins.
      if (w_wr_stat & bus.wdata[STAT_DONE_BIT])    done_d    = 1'b0;
      if (w_wr_stat & bus.wdata[STAT_TIMEOUT_BIT]) timeout_d = 1'b0;
      if (w_wr_stat & bus.wdata[STAT_BADREQ_BIT])  badreq_d  = 1'b0;
      if (go_o) begin
         done_d    = 1'b0;
         timeout_d = 1'b0;
      end
      if (set_done_i)    done_d    = 1'b1;
      if (set_timeout_i) timeout_d = 1'b1;
      if (w_bad_go)      badreq_d  = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dev_q     <= '0;
         mask_q    <= '0;
         write_q   <= 1'b0;
         ie_q      <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         badreq_q  <= 1'b0;
         ready_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         dev_q     <= dev_d;
         mask_q    <= mask_d;
         write_q   <= write_d;
         ie_q      <= ie_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         badreq_q  <= badreq_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.ready  = ready_q;
   assign bus.rdata  = rdata_q;
   assign dev_addr_o = dev_q;
   assign mask_o     = mask_q;
   assign write_o    = write_q;
   assign txdata_o   = tx_q;
   assign irq_o      = ie_q & (done_q | timeout_q);

endmodule
`default_nettype wire

// File: rtl/i2c_mmio_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_mmio_bridge
//  Description : CPU register front end for an I2C master. Latches setup
//                from the bus, launches one transaction by releasing the
//                master's reset, tracks m_busy for completion/timeout and
//                captures the read word.
//  Ports       : clk, reset          - clock, async active-high reset
//                bus                 - CPU bus (slave modport)
//                irq_o               - level interrupt
//                m_rst_o             - master reset (high = parked idle)
//                m_device_addr_o, m_mask_o, m_write_o, m_data_in_o - setup
//                m_data_out_i, m_busy_i - master status/data
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_mmio_bridge
   import i2c_pkg::*;
#(
   parameter int unsigned START_WAIT  = START_WAIT_DEF,
   parameter int unsigned RUN_TIMEOUT = RUN_TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   i2c_mmio_bridge_if.slave     bus,
   output logic                 irq_o,
   output logic                 m_rst_o,
   output logic [6:0]           m_device_addr_o,
   output logic [3:0]           m_mask_o,
   output logic                 m_write_o,
   output logic [31:0]          m_data_in_o,
   input  logic [31:0]          m_data_out_i,
   input  logic                 m_busy_i
);

   localparam int CNT_W = $clog2(max_u(START_WAIT, RUN_TIMEOUT)) + 1;
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WAIT - 1);
   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   bridge_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic w_go;
   logic w_busy;
   logic w_set_done;
   logic w_set_timeout;
   logic w_capture_rx;
   logic w_write;

   assign w_busy = (state_q != ST_IDLE);

   i2c_bridge_regs u_regs (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .busy_i        (w_busy),
      .set_done_i    (w_set_done),
      .set_timeout_i (w_set_timeout),
      .capture_rx_i  (w_capture_rx),
      .m_data_out_i  (m_data_out_i),
      .go_o          (w_go),
      .dev_addr_o    (m_device_addr_o),
      .mask_o        (m_mask_o),
      .write_o       (w_write),
      .txdata_o      (m_data_in_o),
      .irq_o         (irq_o)
   );

   assign m_write_o = w_write;

   // State register: async reset parks the FSM, so m_rst_o rises at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (w_go) begin
               state_d = ST_LAUNCH;
               cnt_d   = '0;
            end
         end
         ST_LAUNCH: begin
            if (m_busy_i) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (cnt_q == START_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_RUN: begin
            if (!m_busy_i) begin
               state_d = ST_FINISH;
            end else if (cnt_q == RUN_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      m_rst_o       = 1'b1;
      w_set_done    = 1'b0;
      w_set_timeout = 1'b0;
      w_capture_rx  = 1'b0;
      case (state_q)
         ST_LAUNCH: begin
            m_rst_o       = 1'b0;
            w_set_timeout = ~m_busy_i & (cnt_q == START_LAST);
         end
         ST_RUN: begin
            m_rst_o       = 1'b0;
            w_set_timeout = m_busy_i & (cnt_q == RUN_LAST);
         end
         ST_FINISH: begin
            w_set_done   = 1'b1;
            w_capture_rx = ~w_write;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_mmio_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_mmio_bridge
//  Description : Self-checking bench for i2c_mmio_bridge: table-driven
//                register accesses plus directed transaction sequences
//                against a simple I2C master busy/data model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_mmio_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        irq;
   logic        m_rst;
   logic [6:0]  m_device_addr;
   logic [3:0]  m_mask;
   logic        m_write;
   logic [31:0] m_data_in;
   logic [31:0] m_data_out = 32'd0;
   logic        m_busy = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   // Master model controls
   int mdl_en    = 0;
   int mdl_delay = 3;
   int mdl_hold  = 500;
   int mcnt      = 0;

   i2c_mmio_bridge_if bus();

   i2c_mmio_bridge dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .irq_o           (irq),
      .m_rst_o         (m_rst),
      .m_device_addr_o (m_device_addr),
      .m_mask_o        (m_mask),
      .m_write_o       (m_write),
      .m_data_in_o     (m_data_in),
      .m_data_out_i    (m_data_out),
      .m_busy_i        (m_busy)
   );

   always #5 clk = ~clk;

   // Master model: counts clocks out of reset, busy for a window.
   always @(negedge clk) begin
      if (m_rst) begin
         mcnt   = 0;
         m_busy = 1'b0;
      end else begin
         mcnt   = mcnt + 1;
         m_busy = (mdl_en != 0) && (mcnt > mdl_delay) && (mcnt <= mdl_delay + mdl_hold);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Caller is at a negedge when sync=0; returns at the negedge of the ack cycle.
   task automatic bus_op(input bit sync, input logic we, input logic [1:0] a,
                         input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
      if (sync) @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = we;
      bus.addr  = a;
      bus.wdata = d;
      bus.wstrb = s;
      @(posedge clk);
      @(negedge clk);
      check("ack", {31'd0, bus.ready}, 32'd1);
      rd      = bus.rdata;
      bus.req = 1'b0;
      bus.we  = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      bus_op(1'b1, 1'b1, a, d, s, dummy);
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] r;
      bus_op(1'b1, 1'b0, a, 32'd0, 4'd0, r);
      check(name, r, exp);
   endtask

   // Count negedges (including the current one) with m_rst low.
   task automatic wait_rst_high(output int low_cycles);
      low_cycles = 1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (m_rst) return;
         low_cycles++;
      end
      check("wait_m_rst_high_timeout", {31'd0, m_rst}, 32'd1);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [31:0] r;
      int          lows;
      int          bad;

      vecs[0] = '{1'b1, 2'd1, 32'h1122_3344, 4'hF, 32'h0};
      vecs[1] = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h1122_3344};
      vecs[2] = '{1'b1, 2'd1, 32'hAABB_CCDD, 4'h5, 32'h0};
      vecs[3] = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h11BB_33DD};
      vecs[4] = '{1'b1, 2'd0, 32'h0001_F17F, 4'h7, 32'h0};
      vecs[5] = '{1'b0, 2'd0, 32'h0,         4'h0, 32'h0001_F17F};
      vecs[6] = '{1'b1, 2'd0, 32'h0000_0000, 4'h1, 32'h0};
      vecs[7] = '{1'b0, 2'd0, 32'h0,         4'h0, 32'h0001_F100};
      vecs[8] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 4'hF, 32'h0};
      vecs[9] = '{1'b0, 2'd2, 32'h0,         4'h0, 32'h0};

      bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0; bus.wstrb = 0;
      repeat (3) @(negedge clk);
      check("reset_m_rst", {31'd0, m_rst}, 32'd1);
      check("reset_ready", {31'd0, bus.ready}, 32'd0);
      check("reset_rdata", bus.rdata, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      reset = 1'b0;
      rd_chk("reset_status", 2'd3, 32'h0);

      // Table-driven register accesses in IDLE
      for (int i = 0; i < 10; i++) begin
         bus_op(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
         if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
      end
      wr(2'd0, 32'h0, 4'h6);               // write=0, mask=0, ie=0
      rd_chk("ctrl_cleared", 2'd0, 32'h0);

      // GO with mask=0: badreq, no launch
      wr(2'd0, 32'h8000_0048, 4'h9);
      check("badgo_m_rst", {31'd0, m_rst}, 32'd1);
      rd_chk("badgo_status", 2'd3, 32'h8);
      rd_chk("badgo_ctrl_go_reads0", 2'd0, 32'h0000_0048);
      wr(2'd3, 32'h8, 4'h1);
      rd_chk("badreq_cleared", 2'd3, 32'h0);

      // Read transaction
      mdl_en = 1; mdl_delay = 3; mdl_hold = 500; m_data_out = 32'hA500_0000;
      wr(2'd0, 32'h8000_8048, 4'hF);
      check("rd_m_rst_low", {31'd0, m_rst}, 32'd0);
      check("rd_m_dev", {25'd0, m_device_addr}, 32'h48);
      check("rd_m_mask", {28'd0, m_mask}, 32'h8);
      check("rd_m_write", {31'd0, m_write}, 32'd0);
      wait_rst_high(lows);
      check("rd_m_rst_low_cycles", lows, 504);
      rd_chk("rd_rxdata", 2'd2, 32'hA500_0000);
      rd_chk("rd_status", 2'd3, 32'h2);

      // Write transaction with a protected TXDATA write during the run
      wr(2'd1, 32'hDEAD_BEEF, 4'hF);
      m_data_out = 32'h0BAD_F00D;
      wr(2'd0, 32'h8000_F148, 4'hF);
      wr(2'd1, 32'h1234_5678, 4'hF);
      rd_chk("wr_txdata_protected", 2'd1, 32'hDEAD_BEEF);
      rd_chk("wr_status_busy", 2'd3, 32'h1);
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (m_rst) break;
         if (m_data_in !== 32'hDEAD_BEEF || m_mask !== 4'hF || m_write !== 1'b1) bad++;
      end
      check("wr_outputs_stable_violations", bad, 0);
      check("wr_m_rst_back_high", {31'd0, m_rst}, 32'd1);
      rd_chk("wr_rxdata_unchanged", 2'd2, 32'hA500_0000);
      rd_chk("wr_status", 2'd3, 32'h2);

      // Clear/set race: W1C done sampled in the FINISH cycle
      mdl_delay = 2; mdl_hold = 5; m_data_out = 32'h5A5A_0001;
      wr(2'd0, 32'h8000_1048, 4'hF);
      wait_rst_high(lows);
      bus_op(1'b0, 1'b1, 2'd3, 32'h2, 4'h1, r);
      rd_chk("race_done_kept", 2'd3, 32'h2);
      rd_chk("race_rxdata", 2'd2, 32'h5A5A_0001);

      // Start timeout with irq
      mdl_en = 0;
      wr(2'd0, 32'h8001_1048, 4'hF);
      wait_rst_high(lows);
      check("to_launch_cycles", lows, 16);
      check("to_irq_set", {31'd0, irq}, 32'd1);
      rd_chk("to_status", 2'd3, 32'h4);
      wr(2'd3, 32'h4, 4'h1);
      check("to_irq_cleared", {31'd0, irq}, 32'd0);
      rd_chk("to_status_cleared", 2'd3, 32'h0);

      // Async reset mid-RUN, landing in a bus ack cycle
      mdl_en = 1; mdl_delay = 3; mdl_hold = 500;
      wr(2'd0, 32'h8001_8048, 4'hF);
      repeat (20) @(negedge clk);
      check("ar_running", {31'd0, m_rst}, 32'd0);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 2'd3; bus.wstrb = 4'h0;
      @(posedge clk);
      #2;
      check("ar_ready_before", {31'd0, bus.ready}, 32'd1);
      reset = 1'b1;
      #1;
      check("ar_m_rst", {31'd0, m_rst}, 32'd1);
      check("ar_ready", {31'd0, bus.ready}, 32'd0);
      check("ar_rdata", bus.rdata, 32'd0);
      bus.req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rd_chk("ar_status", 2'd3, 32'h0);
      rd_chk("ar_ctrl", 2'd0, 32'h0);
      check("ar_m_rst_idle", {31'd0, m_rst}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_mmio_bridge.md
Name: i2c_mmio_bridge

Overview:
CPU-facing register front end that sits directly upstream of the I2C master. It latches the target address, byte mask, direction and TX word from the core's memory bus. It launches one I2C transaction by releasing the master's synchronous reset, then watches the master's busy flag to detect completion. On completion it captures the RX word and raises done/timeout status with an optional level interrupt.

Parameters:
START_WAIT, 16, max clk cycles from launch until m_busy must rise; exceeding it sets timeout.
RUN_TIMEOUT, 65536, max clk cycles m_busy may stay high; exceeding it sets timeout and aborts.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  1  bus request, held until ready
we  in  1  1 = write, 0 = read
addr  in  2  word offset: 0 CTRL, 1 TXDATA, 2 RXDATA, 3 STATUS
wdata  in  32  write data
wstrb  in  4  byte write enables
rdata  out  32  read data, valid while ready = 1
ready  out  1  one-cycle response strobe
irq  out  1  level interrupt
m_rst  out  1  drives the master's reset input; high parks the master idle
m_device_addr  out  7  to master device_addr
m_mask  out  4  to master mask
m_write  out  1  to master write
m_data_in  out  32  to master data_in
m_data_out  in  32  from master data_out
m_busy  in  1  from master busy

Behaviour:
- Reset (async assert, sync release): state IDLE; m_rst=1; ready=0; rdata=0; irq=0; all registers 0.
- Register map:
  - CTRL: [6:0] dev_addr, [8] write, [15:12] mask, [16] ie, [31] GO (write-only, reads 0).
  - TXDATA: [31:0], read/write.
  - RXDATA: read-only; writes are ignored.
  - STATUS: [0] busy (RO, =1 when state != IDLE), [1] done (W1C), [2] timeout (W1C), [3] badreq (W1C).
- Bus handshake:
  - req is sampled when ready=0.
  - Next cycle: ready=1 for exactly one cycle; rdata is registered.
  - Writes take effect on the sampling edge.
  - The requester drops req in the ready cycle.
  - Reads have no side effects.
- Byte strobes apply to CTRL and TXDATA. GO is honoured only when wstrb[3]=1.
- Writes to CTRL/TXDATA while STATUS.busy=1 are dropped but still acked. This keeps the master's inputs stable.
- GO acceptance:
  - GO with mask=0 in IDLE: sets badreq; no launch.
  - GO while busy: ignored.
- FSM states IDLE, LAUNCH, RUN, FINISH:
  - IDLE: m_rst=1. Valid GO -> LAUNCH; clear done/timeout; counter=0.
  - LAUNCH: m_rst=0; counter++.
    - m_busy=1 -> RUN, counter=0.
    - counter==START_WAIT-1 -> set timeout, go to IDLE (m_rst reasserts next cycle, aborting).
  - RUN: m_rst=0; counter++.
    - m_busy=0 -> FINISH.
    - counter==RUN_TIMEOUT-1 -> set timeout, go to IDLE.
  - FINISH (1 cycle): m_rst=1. RXDATA <= m_data_out only if write=0. Set done; -> IDLE.
- m_* data outputs are driven straight from CTRL/TXDATA registers, which are stable across LAUNCH..FINISH.
- irq = ie & (done | timeout).
- Simultaneous W1C clear and hardware set in the same cycle: the set wins.
- Counter width: $clog2(max(START_WAIT, RUN_TIMEOUT)) + 1 bits. It saturates only at the terminal value.
- Reset asserted mid-transaction: the bridge returns to IDLE immediately and m_rst=1 asynchronously. The master resets on its next clk edge.

Decomposition:
- Package i2c_pkg:
  - bridge state enum.
  - Register offset constants (CTRL=0, TXDATA=1, RXDATA=2, STATUS=3).
  - CTRL/STATUS bit-position constants.
  - Default timeout constants.
- Single module. An optional sub-module i2c_bridge_regs (register file + bus ack) is natural; the FSM stays in the top.

Test Plan:
- Read transaction:
  - Stimulus: write CTRL = dev 0x48, write=0, mask=4'b1000, GO. Master model raises busy 3 cycles later, holds 500 cycles, data_out=0xA5000000.
  - Response: m_rst low from the cycle after GO until FINISH. RXDATA=0xA5000000; STATUS=0x2.
- Write transaction:
  - Stimulus: TXDATA=0xDEADBEEF, CTRL write=1, mask=4'b1111, GO.
  - Response: m_data_in=0xDEADBEEF and m_mask=0xF stable throughout. RXDATA unchanged; done=1.
- Start timeout:
  - Stimulus: GO with m_busy held 0.
  - Response: after START_WAIT=16 cycles, timeout=1 and m_rst=1. With ie=1, irq=1. Writing STATUS=0x4 clears timeout and drops irq.
- Protected registers and bad GO:
  - Stimulus: during RUN write TXDATA=0x12345678. Separately, GO with mask=0.
  - Response: the TXDATA write is acked but TXDATA is unchanged. The mask=0 GO sets STATUS.badreq=1 with no launch.
- Clear/set race:
  - Stimulus: W1C of done issued on the same cycle FINISH sets done.
  - Response: done remains 1.
- Async reset mid-RUN:
  - Stimulus: assert reset between edges.
  - Response: m_rst=1, ready=0, STATUS=0 immediately, without waiting for a clock edge.
